// File: rtl/tc_loader_pkg.sv
// Shared types and constants for the program-word loader (tc_program_loader).
package tc_loader_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } state_e;

  function automatic int bpw(input int bit_width);
    return bit_width / 8;
  endfunction

endpackage

// File: rtl/tc_byte_packer.sv
// Packs a little-endian byte stream into BIT_WIDTH words; flags the byte that completes a word.
module tc_byte_packer
  import tc_loader_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 fire,
  input  logic [7:0]           byte_in,
  output logic [BIT_WIDTH-1:0] word_o,
  output logic                 last_o
);

  localparam int BPW   = bpw(BIT_WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BIT_WIDTH-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    last_o = 1'b0;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (fire) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_in;
      if (idx_q == IDX_W'(BPW - 1)) begin
        last_o = 1'b1;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // The completing byte is visible to the loader in the same cycle it arrives.
  assign word_o = word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/tc_program_loader.sv
// Byte-stream to program-memory loader. Optional trailing checksum byte: TC_LOADER_CHECKSUM_EN.
// Byte input: a byte transfers on a rising edge where in_valid & in_ready are both high.
module tc_program_loader
  import tc_loader_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int MEM_WORDS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    word_count,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [BIT_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  state_e               state_q, state_d;
  logic [ADDR_W:0]      cur_addr_q, cur_addr_d;   // extra bit catches 16-bit wrap
  logic [ADDR_W-1:0]    words_left_q, words_left_d;
  logic                 in_ready_q, in_ready_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [BIT_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
`ifdef TC_LOADER_CHECKSUM_EN
  logic [7:0]           sum_q, sum_d;
`endif

  logic                 fire, pk_fire, pk_clear, pk_last;
  logic [BIT_WIDTH-1:0] pk_word;

  assign fire     = in_valid & in_ready_q;
  assign pk_fire  = fire & (state_q == ST_COLLECT);
  assign pk_clear = (state_q == ST_IDLE);

  tc_byte_packer #(.BIT_WIDTH(BIT_WIDTH)) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pk_clear),
    .fire    (pk_fire),
    .byte_in (in_data),
    .word_o  (pk_word),
    .last_o  (pk_last)
  );

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    words_left_d = words_left_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    error_d      = error_q;
`ifdef TC_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d   = {1'b0, base_addr};
          words_left_d = word_count;
          error_d      = 1'b0;
`ifdef TC_LOADER_CHECKSUM_EN
          sum_d        = '0;
`endif
          state_d      = (word_count == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (fire) begin
`ifdef TC_LOADER_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          if (pk_last) begin
            state_d = ST_WRITE;
            // An out-of-range word is still collected but never reaches the memory.
            if (cur_addr_q < (ADDR_W + 1)'(MEM_WORDS)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = cur_addr_q[ADDR_W-1:0];
              wr_data_d = pk_word;
            end else begin
              error_d = 1'b1;
            end
          end
        end
      end
      ST_WRITE: begin
        if (error_q) begin
          state_d = ST_DONE;
        end else begin
          words_left_d = words_left_q - ADDR_W'(1);
          cur_addr_d   = cur_addr_q + (ADDR_W + 1)'(1);
          if (words_left_q == ADDR_W'(1)) begin
`ifdef TC_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
`ifdef TC_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (fire) begin
          if (in_data != sum_q) error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_COLLECT) || (state_d == ST_CHECK);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      words_left_q <= '0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef TC_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      words_left_q <= words_left_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef TC_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_tc_program_loader.sv
// Directed bench for tc_program_loader (BIT_WIDTH=16, MEM_WORDS=256); checksum case needs TC_LOADER_CHECKSUM_EN.
module tb_tc_program_loader;

  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   base_addr = '0;
  logic [15:0]   word_count = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready, wr_en, busy, done, error;
  logic [15:0]   wr_addr;
  logic [BW-1:0] wr_data;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int ready_cnt = 0;
  int overlap_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  tc_program_loader #(.BIT_WIDTH(BW), .MEM_WORDS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // write-port monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
    if (done) done_cnt++;
    if (in_ready) ready_cnt++;
    if (wr_en && in_ready) overlap_cnt++;
  end

  // driver tasks
  task automatic clear_mon();
    exp_q.delete();
    got_q.delete();
    done_cnt = 0;
    ready_cnt = 0;
    overlap_cnt = 0;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    word_count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_byte: in_ready stayed low, got %b want 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic end_stream();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_done_timeout: done got %b want 1", name, done);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run += 7;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    if (wr_addr !== 16'h0) begin tests_failed++; $display("FAIL rst_wr_addr: got %h want 0", wr_addr); end
    if (wr_data !== 16'h0) begin tests_failed++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b want 0", done); end
    if (error !== 1'b0) begin tests_failed++; $display("FAIL rst_error: got %b want 0", error); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic(input bit gap);
    string nm;
    nm = gap ? "toggle" : "basic";
    clear_mon();
    exp_q.push_back(32'h0010_1234);
    exp_q.push_back(32'h0011_5678);
    do_start(16'h0010, 16'd2);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL %s_busy_after_start: got %b want 1", nm, busy); end
    send_byte(8'h34, gap);
    send_byte(8'h12, gap);
    send_byte(8'h78, gap);
    send_byte(8'h56, gap);
`ifdef TC_LOADER_CHECKSUM_EN
    send_byte(8'h14, gap);
`endif
    end_stream();
    wait_done(nm);
    tests_run++;
    if (error !== 1'b0) begin tests_failed++; $display("FAIL %s_error: got %b want 0", nm, error); end
    repeat (2) @(negedge clk);
    tests_run += 4;
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL %s_done_cnt: got %0d want 1", nm, done_cnt); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL %s_busy_end: got %b want 0", nm, busy); end
    if (overlap_cnt !== 0) begin tests_failed++; $display("FAIL %s_ready_in_write: got %0d want 0", nm, overlap_cnt); end
    if (got_q.size() !== exp_q.size()) begin
      tests_failed++; $display("FAIL %s_write_count: got %0d want %0d", nm, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL %s_write%0d: got %h want %h", nm, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_count();
    clear_mon();
    do_start(16'h0005, 16'd0);
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL zero_done_next_cycle: got %b want 1", done); end
    repeat (3) @(negedge clk);
    tests_run += 4;
    if (got_q.size() !== 0) begin tests_failed++; $display("FAIL zero_writes: got %0d want 0", got_q.size()); end
    if (ready_cnt !== 0) begin tests_failed++; $display("FAIL zero_in_ready: got %0d want 0", ready_cnt); end
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy: got %b want 0", busy); end
  endtask

  task automatic test_out_of_range();
    clear_mon();
    do_start(16'h00FF, 16'd2);
    send_byte(8'hCD, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    end_stream();
    wait_done("oor");
    tests_run++;
    if (error !== 1'b1) begin tests_failed++; $display("FAIL oor_error: got %b want 1", error); end
    repeat (3) @(negedge clk);
    tests_run += 5;
    if (error !== 1'b1) begin tests_failed++; $display("FAIL oor_error_sticky: got %b want 1", error); end
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL oor_done_cnt: got %0d want 1", done_cnt); end
    if (got_q.size() !== 1) begin tests_failed++; $display("FAIL oor_write_count: got %0d want 1", got_q.size()); end
    if (wr_addr !== 16'h00FF) begin tests_failed++; $display("FAIL oor_hold_addr: got %h want 00ff", wr_addr); end
    if (wr_data !== 16'hABCD) begin tests_failed++; $display("FAIL oor_hold_data: got %h want abcd", wr_data); end
    if (got_q.size() > 0) begin
      tests_run++;
      if (got_q[0] !== 32'h00FF_ABCD) begin tests_failed++; $display("FAIL oor_write0: got %h want 00ffabcd", got_q[0]); end
    end
  endtask

  task automatic test_reset_mid_load();
    clear_mon();
    do_start(16'h0020, 16'd1);
    tests_run++;
    if (error !== 1'b0) begin tests_failed++; $display("FAIL mid_error_cleared: got %b want 0", error); end
    send_byte(8'h11, 1'b0);
    end_stream();
    rst_n = 1'b0;
    #1;
    tests_run += 4;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (wr_addr !== 16'h0) begin tests_failed++; $display("FAIL mid_wr_addr: got %h want 0", wr_addr); end
    if (wr_data !== 16'h0) begin tests_failed++; $display("FAIL mid_wr_data: got %h want 0", wr_data); end
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (got_q.size() !== 0) begin tests_failed++; $display("FAIL mid_no_write: got %0d want 0", got_q.size()); end
    do_start(16'h0030, 16'd1);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
`ifdef TC_LOADER_CHECKSUM_EN
    send_byte(8'hAD, 1'b0);
`endif
    end_stream();
    wait_done("mid");
    tests_run += 2;
    if (error !== 1'b0) begin tests_failed++; $display("FAIL mid_reload_error: got %b want 0", error); end
    if (got_q.size() !== 1) begin tests_failed++; $display("FAIL mid_reload_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      tests_run++;
      if (got_q[0] !== 32'h0030_BEEF) begin tests_failed++; $display("FAIL mid_reload_write: got %h want 0030beef", got_q[0]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    exp_q.push_back(32'h0040_0201);
    exp_q.push_back(32'h0041_0403);
    exp_q.push_back(32'h0050_55AA);
    do_start(16'h0040, 16'd2);
    do_start(16'h0080, 16'd5);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
`ifdef TC_LOADER_CHECKSUM_EN
    send_byte(8'h0A, 1'b0);
`endif
    end_stream();
    wait_done("b2b_first");
    do_start(16'h0050, 16'd1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h55, 1'b0);
`ifdef TC_LOADER_CHECKSUM_EN
    send_byte(8'hFF, 1'b0);
`endif
    end_stream();
    wait_done("b2b_second");
    repeat (2) @(negedge clk);
    tests_run += 3;
    if (error !== 1'b0) begin tests_failed++; $display("FAIL b2b_error: got %b want 0", error); end
    if (done_cnt !== 2) begin tests_failed++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); end
    if (got_q.size() !== exp_q.size()) begin
      tests_failed++; $display("FAIL b2b_write_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL b2b_write%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef TC_LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic [7:0] cks, input logic want_err);
    clear_mon();
    do_start(16'h0000, 16'd2);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(cks, 1'b0);
    end_stream();
    wait_done("cks");
    tests_run += 2;
    if (error !== want_err) begin tests_failed++; $display("FAIL cks_error_%h: got %b want %b", cks, error, want_err); end
    if (got_q.size() !== 2) begin tests_failed++; $display("FAIL cks_write_count_%h: got %0d want 2", cks, got_q.size()); end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_zero_count();
    test_out_of_range();
    test_reset_mid_load();
    test_back_to_back();
`ifdef TC_LOADER_CHECKSUM_EN
    test_checksum(8'h0A, 1'b0);
    test_checksum(8'h0B, 1'b1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
